// File: rtl/level_sequencer.sv
// Level/score/bird bookkeeping and game-flow FSM for the Angry Birds VGA game.
// Define LEVEL_CLEAR_BONUS_EN to award BONUS_POINTS per unused bird on level clear.
module level_sequencer #(
    parameter int NUM_LEVELS         = 3,
    parameter int BIRDS_PER_LEVEL    = 3,
    parameter int PIGS_BASE          = 2,
    parameter int PIG_POINTS         = 500,
    parameter int CLEAR_DELAY_FRAMES = 60,
    parameter int BONUS_POINTS       = 1000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame_i,
    input  logic        start_key_i,
    input  logic        collision_bird_pig_i,
    input  logic        bird_launch_i,
    input  logic        bird_stopped_i,
    output logic        pigs_left_o,
    output logic [2:0]  pigs_remaining_o,
    output logic [2:0]  birds_left_o,
    output logic [3:0]  current_level_o,
    output logic [15:0] score_o,
    output logic        level_start_o,
    output logic        game_over_o,
    output logic        game_won_o
);

`ifdef LEVEL_CLEAR_BONUS_EN
    localparam bit BONUS_EN = 1'b1;
`else
    localparam bit BONUS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_CLEAR, S_LOST, S_WON} state_e;

    state_e      state_q, state_d;
    logic [2:0]  pigs_q, pigs_d, birds_q, birds_d;
    logic [3:0]  level_q, level_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  frames_q, frames_d;
    logic        pl_q, pl_d, ls_q, ls_d, over_q, over_d, won_q, won_d;
    logic        latch_q, latch_d, seen_q, seen_d;

    logic        hit, to_clear, clear_done, restart, enter_load;
    logic [2:0]  birds_dec, pigs_dec, pigs_load;
    logic [4:0]  pigs_sum;
    logic [31:0] add_amt, score_sum;
    logic [15:0] score_sat;

    assign hit        = (state_q == S_PLAY) && collision_bird_pig_i && !latch_q;
    assign birds_dec  = (bird_launch_i && birds_q != 3'd0) ? birds_q - 3'd1 : birds_q;
    assign pigs_dec   = hit ? pigs_q - 3'd1 : pigs_q;
    assign to_clear   = (pigs_dec == 3'd0);
    assign clear_done = startOfFrame_i && (frames_q == 8'(CLEAR_DELAY_FRAMES - 1));
    assign restart    = start_key_i && (state_q == S_IDLE || state_q == S_LOST || state_q == S_WON);
    assign pigs_sum   = 5'(PIGS_BASE) + {1'b0, level_q};
    assign pigs_load  = (pigs_sum > 5'd7) ? 3'd7 : pigs_sum[2:0];

    // Pig points and clear bonus are summed before the single saturation.
    always_comb begin
        add_amt = hit ? 32'(PIG_POINTS) : 32'd0;
        if (BONUS_EN && state_q == S_PLAY && to_clear)
            add_amt = add_amt + 32'(birds_dec) * 32'(BONUS_POINTS);
    end
    assign score_sum = 32'(score_q) + add_amt;
    assign score_sat = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_LOST, S_WON: if (start_key_i) state_d = S_LOAD;
            S_LOAD:  state_d = S_PLAY;
            S_PLAY: begin
                if (to_clear)                                  state_d = S_CLEAR;
                else if (bird_stopped_i && birds_dec == 3'd0)  state_d = S_LOST;
            end
            S_CLEAR: if (clear_done) state_d = (level_q == 4'(NUM_LEVELS - 1)) ? S_WON : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);

    always_comb begin
        pigs_d   = pigs_q;
        birds_d  = birds_q;
        level_d  = level_q;
        score_d  = score_q;
        frames_d = frames_q;
        ls_d     = 1'b0;
        over_d   = (state_d == S_LOST) || (state_d == S_WON);
        won_d    = (state_d == S_WON);
        // A frame with no overlap at all re-arms hit counting.
        seen_d   = startOfFrame_i ? collision_bird_pig_i : (seen_q | collision_bird_pig_i);
        latch_d  = (startOfFrame_i && !seen_q) ? 1'b0 : latch_q;
        if (restart) begin
            score_d = 16'd0;
            level_d = 4'd0;
        end
        case (state_q)
            S_LOAD: begin
                pigs_d  = pigs_load;
                birds_d = 3'(BIRDS_PER_LEVEL);
                ls_d    = 1'b1;
            end
            S_PLAY: begin
                birds_d = birds_dec;
                pigs_d  = pigs_dec;
                score_d = score_sat;
                if (hit) latch_d = 1'b1;
            end
            S_CLEAR: begin
                if (startOfFrame_i) frames_d = frames_q + 8'd1;
                if (clear_done && state_d == S_LOAD) level_d = level_q + 4'd1;
            end
            default: ;
        endcase
        if (enter_load) begin
            latch_d  = 1'b0;
            seen_d   = 1'b0;
            frames_d = 8'd0;
        end
        pl_d = (pigs_d != 3'd0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pigs_q   <= '0;
            birds_q  <= '0;
            level_q  <= '0;
            score_q  <= '0;
            frames_q <= '0;
            pl_q     <= 1'b0;
            ls_q     <= 1'b0;
            over_q   <= 1'b0;
            won_q    <= 1'b0;
            latch_q  <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            pigs_q   <= pigs_d;
            birds_q  <= birds_d;
            level_q  <= level_d;
            score_q  <= score_d;
            frames_q <= frames_d;
            pl_q     <= pl_d;
            ls_q     <= ls_d;
            over_q   <= over_d;
            won_q    <= won_d;
            latch_q  <= latch_d;
            seen_q   <= seen_d;
        end
    end

    assign pigs_left_o      = pl_q;
    assign pigs_remaining_o = pigs_q;
    assign birds_left_o     = birds_q;
    assign current_level_o  = level_q;
    assign score_o          = score_q;
    assign level_start_o    = ls_q;
    assign game_over_o      = over_q;
    assign game_won_o       = won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: game-rule model compared every cycle plus directed literal checks.
// Instance u1 uses a large PIG_POINTS so score saturation is reached quickly.
module tb_level_sequencer;
    localparam int NL = 3, BPL = 3, BASE = 2, DLY = 60, BON = 1000;
`ifdef LEVEL_CLEAR_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic clk = 1'b0, resetN = 1'b0;
    logic sof = 1'b0, sk = 1'b0, col = 1'b0, ln = 1'b0, st = 1'b0;
    always #5 clk = ~clk;

    logic        pl[2], ls[2], go[2], gw[2];
    logic [2:0]  pr[2], bl[2];
    logic [3:0]  lv[2];
    logic [15:0] sc[2];

    level_sequencer u0 (
        .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .start_key_i(sk),
        .collision_bird_pig_i(col), .bird_launch_i(ln), .bird_stopped_i(st),
        .pigs_left_o(pl[0]), .pigs_remaining_o(pr[0]), .birds_left_o(bl[0]),
        .current_level_o(lv[0]), .score_o(sc[0]), .level_start_o(ls[0]),
        .game_over_o(go[0]), .game_won_o(gw[0]));

    level_sequencer #(.PIG_POINTS(30000)) u1 (
        .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .start_key_i(sk),
        .collision_bird_pig_i(col), .bird_launch_i(ln), .bird_stopped_i(st),
        .pigs_left_o(pl[1]), .pigs_remaining_o(pr[1]), .birds_left_o(bl[1]),
        .current_level_o(lv[1]), .score_o(sc[1]), .level_start_o(ls[1]),
        .game_over_o(go[1]), .game_won_o(gw[1]));

    int checks = 0, failures = 0, cyc_n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Game-rule model: one record per instance, advanced once per clock.
    typedef enum int {P_IDLE, P_LOAD, P_PLAY, P_CLEAR, P_LOST, P_WON} phase_e;
    typedef struct {
        phase_e ph;
        int pigs, birds, level, score, frames;
        bit ls, over, won, armed, seen;
    } mdl_t;
    mdl_t m[2];

    function automatic mdl_t reset_mdl();
        mdl_t r;
        r.ph = P_IDLE; r.pigs = 0; r.birds = 0; r.level = 0; r.score = 0; r.frames = 0;
        r.ls = 0; r.over = 0; r.won = 0; r.armed = 1; r.seen = 0;
        return r;
    endfunction

    function automatic mdl_t enter_load(input mdl_t x);
        x.ph = P_LOAD; x.armed = 1; x.seen = 0; x.frames = 0; x.over = 0; x.won = 0;
        return x;
    endfunction

    function automatic mdl_t step(input mdl_t x, input int pts,
                                  input bit f, input bit k, input bit c, input bit l, input bit s);
        mdl_t n = x;
        int add, b;
        n.ls = 0;
        n.seen = f ? c : (x.seen || c);
        if (f && !x.seen) n.armed = 1;
        case (x.ph)
            P_IDLE, P_LOST, P_WON:
                if (k) begin n.score = 0; n.level = 0; n = enter_load(n); end
            P_LOAD: begin
                n.pigs = (BASE + x.level > 7) ? 7 : BASE + x.level;
                n.birds = BPL; n.ls = 1; n.ph = P_PLAY;
            end
            P_PLAY: begin
                b = (l && x.birds > 0) ? x.birds - 1 : x.birds;
                n.birds = b;
                add = 0;
                if (c && x.armed) begin n.armed = 0; n.pigs = x.pigs - 1; add = pts; end
                if (n.pigs == 0) begin
                    n.ph = P_CLEAR;
                    if (BONUS_ON) add += b * BON;
                end else if (s && b == 0) begin
                    n.ph = P_LOST; n.over = 1;
                end
                n.score = (x.score + add > 65535) ? 65535 : x.score + add;
            end
            P_CLEAR:
                if (f) begin
                    n.frames = x.frames + 1;
                    if (n.frames == DLY) begin
                        if (x.level == NL - 1) begin n.ph = P_WON; n.over = 1; n.won = 1; end
                        else begin n.level = x.level + 1; n = enter_load(n); end
                    end
                end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < 2; k++) m[k] <= reset_mdl();
        end else begin
            for (int k = 0; k < 2; k++) m[k] <= step(m[k], (k == 1) ? 30000 : 500, sof, sk, col, ln, st);
        end
    end

    function automatic logic [31:0] dut_vec(input int k);
        return {2'b0, pl[k], pr[k], bl[k], lv[k], sc[k], ls[k], go[k], gw[k]};
    endfunction

    function automatic logic [31:0] mdl_vec(input int k);
        return {2'b0, m[k].pigs != 0, 3'(m[k].pigs), 3'(m[k].birds), 4'(m[k].level),
                16'(m[k].score), m[k].ls, m[k].over, m[k].won};
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) chk($sformatf("model_u%0d", k), dut_vec(k), mdl_vec(k));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        cyc_n++;
        sof = (cyc_n % 8 == 0);
    endtask

    task automatic sofs(input int n);
        int c = 0;
        while (c < n) begin
            if (sof) c++;
            cyc();
        end
    endtask

    task automatic hit1();
        sofs(2);
        col = 1; cyc(); col = 0;
    endtask

    task automatic launch();
        ln = 1; cyc(); ln = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        chk("reset_u0", dut_vec(0), 32'd0);
        chk("reset_u1", dut_vec(1), 32'd0);
        resetN = 1; cyc();

        sk = 1; cyc(); sk = 0;
        chk("ls_before_load", 32'(ls[0]), 32'd0);
        cyc();
        chk("ls_pulse", 32'(ls[0]), 32'd1);
        chk("pigs_l0", 32'(pr[0]), 32'd2);
        chk("birds_l0", 32'(bl[0]), 32'd3);
        chk("level_l0", 32'(lv[0]), 32'd0);
        chk("pigs_left_l0", 32'(pl[0]), 32'd1);
        cyc();
        chk("ls_one_cycle", 32'(ls[0]), 32'd0);

        // Three frames of sustained overlap count once; re-armed after a clean frame.
        col = 1; cyc();
        chk("hit1_pigs", 32'(pr[0]), 32'd1);
        chk("hit1_score", 32'(sc[0]), 32'd500);
        sofs(3); col = 0;
        chk("held_no_rehit", 32'(pr[0]), 32'd1);
        sofs(2);
        col = 1; cyc(); col = 0;
        chk("hit2_pigs", 32'(pr[0]), 32'd0);
        chk("hit2_score", 32'(sc[0]), 32'd1000);
        chk("hit2_pigs_left", 32'(pl[0]), 32'd0);
        chk("hit2_score_u1", 32'(sc[1]), 32'd60000);

        sofs(59);
        chk("clear_59_level", 32'(lv[0]), 32'd0);
        sofs(1);
        chk("clear_60_level", 32'(lv[0]), 32'd1);
        cyc();
        chk("l1_ls", 32'(ls[0]), 32'd1);
        chk("l1_pigs", 32'(pr[0]), 32'd3);

        hit1();
        chk("l1_score", 32'(sc[0]), 32'd1500);
        chk("sat_u1", 32'(sc[1]), 32'd65535);
        hit1();
        chk("sat_hold_u1", 32'(sc[1]), 32'd65535);
        launch(); launch(); launch();
        chk("birds_zero", 32'(bl[0]), 32'd0);
        launch();
        chk("fourth_launch", 32'(bl[0]), 32'd0);

        // Last pig and final stop together: level clears, game not lost.
        sofs(2);
        col = 1; st = 1; cyc(); col = 0; st = 0;
        chk("tie_pigs", 32'(pr[0]), 32'd0);
        chk("tie_not_lost", 32'(go[0]), 32'd0);
        chk("tie_score", 32'(sc[0]), 32'd2500);
        sofs(60); cyc();
        chk("l2_level", 32'(lv[0]), 32'd2);
        chk("l2_pigs", 32'(pr[0]), 32'd4);

        launch(); launch();
        ln = 1; st = 1; cyc(); ln = 0; st = 0;
        chk("lost_over", 32'(go[0]), 32'd1);
        chk("lost_won", 32'(gw[0]), 32'd0);
        repeat (5) cyc();
        chk("lost_hold", 32'(go[0]), 32'd1);

        // Restart and win all levels; one bird spent in level 0.
        sk = 1; cyc(); sk = 0; cyc();
        chk("restart_score", 32'(sc[0]), 32'd0);
        chk("restart_level", 32'(lv[0]), 32'd0);
        chk("restart_over", 32'(go[0]), 32'd0);
        launch();
        hit1(); hit1();
        chk("bonus_score", 32'(sc[0]), BONUS_ON ? 32'd3000 : 32'd1000);
        sofs(60); cyc();
        hit1(); hit1(); hit1();
        sofs(60); cyc();
        hit1(); hit1(); hit1(); hit1();
        sofs(59);
        chk("won_not_yet", 32'(gw[0]), 32'd0);
        sofs(1);
        chk("won", 32'(gw[0]), 32'd1);
        chk("won_over", 32'(go[0]), 32'd1);

        // Asynchronous reset in the middle of CLEAR.
        sk = 1; cyc(); sk = 0; cyc();
        hit1(); hit1();
        sofs(10);
        resetN = 0;
        #1;
        chk("async_reset_u0", dut_vec(0), 32'd0);
        chk("async_reset_u1", dut_vec(1), 32'd0);
        repeat (2) cyc();
        resetN = 1;
        repeat (4) cyc();
        chk("idle_after_reset", 32'(pr[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
